// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: one-shot MDU start, shadow latency counter, HI/LO hazard stall and sticky protocol error
module md_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_md,
  input  logic        e_valid,
  input  logic        e_md,
  input  logic [2:0]  e_mdop,
  input  logic        e_hold,
  input  logic        e_kill,
  input  logic        mdu_busy,
  output logic        mdu_start,
  output logic [2:0]  mdu_op,
  output logic        stall_md,
  output logic [3:0]  cnt,
  output logic        err,
  output logic [15:0] stall_cycles
);
  localparam logic [3:0] MLAT = 4'(MULT_LAT);
  localparam logic [3:0] DLAT = 4'(DIV_LAT);
  logic issued, start_class, busy, bad;
  assign start_class = e_valid & e_md & e_mdop[2] & ~e_kill;
  assign mdu_start = start_class & ~issued;
  assign busy = cnt != 4'd0;
  assign stall_md = d_md & (mdu_start | start_class | busy);
  assign mdu_op = (e_valid & e_md) ? e_mdop : 3'd0;
  // ops 0-3 are HI/LO moves: touching HI/LO mid-operation is a hazard escape
  assign bad = (mdu_busy != busy) | (busy & e_valid & e_md & ~e_mdop[2]) | (busy & mdu_start);
  always_ff @(posedge clk) begin
    if (reset) begin
      issued       <= 1'b0;
      cnt          <= 4'd0;
      err          <= 1'b0;
      stall_cycles <= 16'd0;
    end else begin
      issued       <= e_hold & (issued | mdu_start);
      cnt          <= mdu_start ? (e_mdop[1] ? DLAT : MLAT) : busy ? cnt - 4'd1 : cnt;
      err          <= err | bad;
      stall_cycles <= (stall_md && stall_cycles != 16'hFFFF) ? stall_cycles + 16'd1 : stall_cycles;
    end
  end
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: scoreboard bench for md_issue_ctrl against a timeline-based reference model
module tb_md_issue_ctrl;
  localparam int ML = 5;
  localparam int DL = 10;
  logic clk = 1'b0, reset = 1'b1, d_md = 1'b0, e_valid = 1'b0, e_md = 1'b0;
  logic [2:0] e_mdop = 3'd0;
  logic e_hold = 1'b0, e_kill = 1'b0, mdu_busy = 1'b0;
  logic mdu_start, stall_md, err;
  logic [2:0] mdu_op;
  logic [3:0] cnt;
  logic [15:0] stall_cycles;
  int tests = 0, fails = 0;

  md_issue_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .d_md(d_md), .e_valid(e_valid), .e_md(e_md),
    .e_mdop(e_mdop), .e_hold(e_hold), .e_kill(e_kill), .mdu_busy(mdu_busy),
    .mdu_start(mdu_start), .mdu_op(mdu_op), .stall_md(stall_md), .cnt(cnt),
    .err(err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic st;
    logic [2:0] op;
    logic sl;
    logic [3:0] cn;
    logic er;
    logic [15:0] sc;
  } exp_t;
  exp_t q[$];

  // model: the MDU operation occupies cycles up to busy_end; cycle number advances per edge
  int cyc = 0, busy_end = -1, stall_m = 0;
  logic err_m = 1'b0, held = 1'b0;

  function automatic int cnt_m();
    return (busy_end >= cyc) ? busy_end - cyc + 1 : 0;
  endfunction

  function automatic void chk(input string n, input logic [15:0] a, input logic [15:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction

  task automatic step(input logic rs, dm, v, m, input logic [2:0] op, input logic h, k, bf, input bit push);
    int c;
    logic sc, st, sl;
    c  = cnt_m();
    sc = v & m & op[2] & ~k;
    st = sc & ~held;
    sl = dm & (sc | (c != 0));
    reset = rs; d_md = dm; e_valid = v; e_md = m; e_mdop = op; e_hold = h; e_kill = k;
    mdu_busy = bf ? 1'b0 : (c != 0);
    if (push) q.push_back(exp_t'{st, (v & m) ? op : 3'd0, sl, 4'(c), err_m, 16'(stall_m)});
    @(posedge clk);
    if (rs) begin
      busy_end = -1; held = 1'b0; err_m = 1'b0; stall_m = 0;
    end else begin
      err_m = err_m | (mdu_busy != (c != 0)) | ((c != 0) & v & m & ~op[2]) | ((c != 0) & st);
      if (sl) stall_m = (stall_m == 65535) ? 65535 : stall_m + 1;
      held = h & (held | st);
      if (st) busy_end = cyc + (op[1] ? DL : ML);
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input logic dm);
    for (int i = 0; i < n; i++) step(1'b0, dm, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rst();
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("mdu_start", 16'(mdu_start), 16'(e.st));
        chk("mdu_op", 16'(mdu_op), 16'(e.op));
        chk("stall_md", 16'(stall_md), 16'(e.sl));
        chk("cnt", 16'(cnt), 16'(e.cn));
        chk("err", 16'(err), 16'(e.er));
        chk("stall_cycles", stall_cycles, e.sc);
      end
    end
  end

  initial begin
    logic rs, dm, v, m, h, k, bf;
    logic [2:0] op;
    int c;
    bit inj;
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst();
    // mult, no hold: cnt 5..1 then 0
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(6, 1'b0);
    chk("mult_done_err", 16'(err), 16'd0);
    // divu with mfhi waiting in D: 11 stall cycles, then mfhi in E at cnt=0
    rst();
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(10, 1'b1);
    chk("divu_stall_cycles", stall_cycles, 16'd11);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    // div held three cycles, then released
    rst();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(8, 1'b0);
    chk("div_hold_cnt", 16'(cnt), 16'd0);
    chk("div_hold_err", 16'(err), 16'd0);
    // killed multu: nothing happens, no stall
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);
    // reset while cnt=7
    rst();
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b0);
    chk("cnt_before_reset", 16'(cnt), 16'd7);
    rst();
    chk("cnt_after_reset", 16'(cnt), 16'd0);
    idle(2, 1'b0);
    // fault: MDU never raises busy
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b0);
    chk("busy_fault_err", 16'(err), 16'd1);
    // fault: mflo in E at cnt=3
    rst();
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4, 1'b0);
    chk("mflo_fault_err", 16'(err), 16'd1);
    // fault: second start while busy
    rst();
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(7, 1'b0);
    rst();
    // randomized traffic, mostly legal, with sparse faults and resets
    for (int i = 0; i < 3000; i++) begin
      c   = cnt_m();
      inj = $urandom_range(0, 99) == 0;
      rs  = $urandom_range(0, 49) == 0;
      dm  = 1'($urandom);
      v   = 1'($urandom);
      m   = 1'($urandom);
      op  = 3'($urandom);
      h   = $urandom_range(0, 3) == 0;
      k   = $urandom_range(0, 7) == 0;
      if (!inj && c != 0 && v && m && (!op[2] || (!k && !held))) m = 1'b0;
      bf  = inj && c != 0 && $urandom_range(0, 1) == 1;
      step(rs, dm, v, m, op, h, k, bf, 1'b1);
    end
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
